// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared LC-3b types used by the pipeline hazard controller.
package lc3b_types;
  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_reg;

  typedef enum logic [0:0] {
    HZD_RUN        = 1'b0,
    HZD_FLUSH_PEND = 1'b1
  } lc3b_hzd_state;

  localparam lc3b_word PERF_SAT = 16'hFFFF;

  function automatic lc3b_word sat_inc(input lc3b_word v);
    return (v == PERF_SAT) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/pipeline_hazard_ctrl_perf.sv
// Three 16-bit saturating event counters; only instantiated under PIPE_HZD_PERF_EN.
module hzd_perf_counters
  import lc3b_types::*;
(
  input  logic     clk,
  input  logic     reset_n,
  input  logic     i_stall_cyc,
  input  logic     i_redirect,
  input  logic     i_load_use,
  output lc3b_word o_stall_cycles,
  output lc3b_word o_redirects,
  output lc3b_word o_load_use
);
  lc3b_word r_stall, r_redir, r_lu;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_stall <= '0;
      r_redir <= '0;
      r_lu    <= '0;
    end else begin
      if (i_stall_cyc) r_stall <= sat_inc(r_stall);
      if (i_redirect)  r_redir <= sat_inc(r_redir);
      if (i_load_use)  r_lu    <= sat_inc(r_lu);
    end
  end

  assign o_stall_cycles = r_stall;
  assign o_redirects    = r_redir;
  assign o_load_use     = r_lu;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// LC-3b stall/flush controller: D-cache wait > MEM redirect > I-cache wait > load-use.
// Define PIPE_HZD_PERF_EN to add saturating perf counter outputs.
module pipeline_hazard_ctrl
  import lc3b_types::*;
(
  input  logic     clk,
  input  logic     reset_n,
  input  logic     icache_resp,
  input  logic     dcache_req,
  input  logic     dcache_resp,
  input  logic     mem_br_taken,
  input  lc3b_word mem_target,
  input  lc3b_reg  id_sr1_reg,
  input  lc3b_reg  id_sr2_reg,
  input  logic     id_uses_sr1,
  input  logic     id_uses_sr2,
  input  logic     ex_is_load,
  input  lc3b_reg  ex_dest,
  output logic     pc_load_en,
  output logic     pc_redirect,
  output lc3b_word redirect_pc,
  output logic     stall_if_id,
  output logic     stall_id_ex,
  output logic     stall_ex_mem,
  output logic     flush_if_id,
  output logic     flush_id_ex,
  output logic     flush_ex_mem,
  output logic     flush_mem_wb
`ifdef PIPE_HZD_PERF_EN
  ,
  output lc3b_word perf_stall_cycles,
  output lc3b_word perf_redirects,
  output lc3b_word perf_load_use
`endif
);
  lc3b_hzd_state r_state, w_next;
  lc3b_word      r_tgt_q, w_tgt_d;
  logic          w_dmem_busy, w_load_use;

  assign w_dmem_busy = dcache_req & ~dcache_resp;
  assign w_load_use  = ex_is_load & ((id_uses_sr1 & (id_sr1_reg == ex_dest)) |
                                     (id_uses_sr2 & (id_sr2_reg == ex_dest)));

  always_comb begin
    pc_load_en   = 1'b0;
    pc_redirect  = 1'b0;
    redirect_pc  = (r_state == HZD_FLUSH_PEND) ? r_tgt_q : mem_target;
    stall_if_id  = 1'b0;
    stall_id_ex  = 1'b0;
    stall_ex_mem = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    flush_mem_wb = 1'b0;
    w_next       = r_state;
    w_tgt_d      = r_tgt_q;
    if (!reset_n) begin
      flush_if_id  = 1'b1;
      flush_id_ex  = 1'b1;
      flush_ex_mem = 1'b1;
      flush_mem_wb = 1'b1;
    end else if (w_dmem_busy) begin
      // Full freeze in either state; WB drains with NOPs.
      stall_if_id  = 1'b1;
      stall_id_ex  = 1'b1;
      stall_ex_mem = 1'b1;
      flush_mem_wb = 1'b1;
    end else if (r_state == HZD_FLUSH_PEND) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
      if (icache_resp) begin
        pc_load_en  = 1'b1;
        pc_redirect = 1'b1;
        w_next      = HZD_RUN;
      end
    end else if (mem_br_taken) begin
      flush_if_id  = 1'b1;
      flush_id_ex  = 1'b1;
      flush_ex_mem = 1'b1;
      if (icache_resp) begin
        pc_load_en  = 1'b1;
        pc_redirect = 1'b1;
      end else begin
        w_tgt_d = mem_target;
        w_next  = HZD_FLUSH_PEND;
      end
    end else if (!icache_resp || w_load_use) begin
      stall_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else begin
      pc_load_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= HZD_RUN;
      r_tgt_q <= '0;
    end else begin
      r_state <= w_next;
      r_tgt_q <= w_tgt_d;
    end
  end

`ifdef PIPE_HZD_PERF_EN
  logic w_stall_cyc, w_br_accept, w_lu_bubble;
  assign w_stall_cyc = reset_n & ~pc_load_en;
  assign w_br_accept = reset_n & (r_state == HZD_RUN) & ~w_dmem_busy & mem_br_taken;
  assign w_lu_bubble = reset_n & (r_state == HZD_RUN) & ~w_dmem_busy & ~mem_br_taken &
                       icache_resp & w_load_use;

  hzd_perf_counters u_perf (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_stall_cyc    (w_stall_cyc),
    .i_redirect     (w_br_accept),
    .i_load_use     (w_lu_bubble),
    .o_stall_cycles (perf_stall_cycles),
    .o_redirects    (perf_redirects),
    .o_load_use     (perf_load_use)
  );
`endif
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the LC-3b five-stage pipeline. It drives the `stall_pipeline`-style hold inputs and the NOP-insert flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers, plus PC load and redirect. It resolves four hazard sources with fixed priority: D-cache wait, taken redirect in MEM, I-cache wait and load-use. Redirects that arrive during an outstanding I-fetch are buffered internally.

## Interface
Parameters: none.

Clock and reset:
- clk  in  1  single clock; all state updates on rising edge
- reset_n  in  1  reset is synchronous and active-low

Memory handshake:
- icache_resp  in  1  IF fetch complete. The I-cache holds this high while PC is unchanged.
- dcache_req  in  1  valid MEM-stage load/store request
- dcache_resp  in  1  D-cache access complete this cycle

Redirect:
- mem_br_taken  in  1  MEM-stage taken BR/JMP/JSR/TRAP
- mem_target  in  16  lc3b_word redirect address

Load-use detection:
- id_sr1_reg, id_sr2_reg  in  3  lc3b_reg ID source registers
- id_uses_sr1, id_uses_sr2  in  1  source actually read
- ex_is_load  in  1  EX holds LDR/LDB/LDI
- ex_dest  in  3  lc3b_reg EX destination register

PC control:
- pc_load_en  out  1  PC register load
- pc_redirect  out  1  PC mux selects redirect_pc
- redirect_pc  out  16  redirect address

Pipeline register control:
- stall_if_id, stall_id_ex, stall_ex_mem  out  1  hold the register
- flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb  out  1  load NOP control word

## Operation
State machine (lc3b_hzd_state): HZD_RUN, HZD_FLUSH_PEND. Internal signals:
- dmem_busy = dcache_req & ~dcache_resp
- load_use = ex_is_load & ((id_uses_sr1 & id_sr1_reg==ex_dest) | (id_uses_sr2 & id_sr2_reg==ex_dest))

HZD_RUN, first matching rule wins:
1. dmem_busy:
   - pc_load_en=0
   - stall_if_id=stall_id_ex=stall_ex_mem=1
   - flush_mem_wb=1
   - mem_br_taken and icache_resp are ignored
2. mem_br_taken:
   - flush_if_id=flush_id_ex=flush_ex_mem=1
   - if icache_resp: pc_load_en=1, pc_redirect=1, redirect_pc=mem_target
   - else: latch mem_target into tgt_q, pc_load_en=0, next state HZD_FLUSH_PEND
3. ~icache_resp: pc_load_en=0, stall_if_id=1, flush_id_ex=1.
4. load_use: pc_load_en=0, stall_if_id=1, flush_id_ex=1 (exactly one bubble).
5. Otherwise: pc_load_en=1, all stall/flush outputs 0.

HZD_FLUSH_PEND:
- The wrong-path fetch completes and is discarded. redirect_pc=tgt_q.
- dmem_busy: apply rule 1 and stay in HZD_FLUSH_PEND.
- Otherwise: flush_if_id=flush_id_ex=1 and pc_load_en=0 every cycle.
  - On icache_resp: pc_load_en=1, pc_redirect=1, next state HZD_RUN.
- mem_br_taken is ignored (MEM holds a bubble).

Output defaults and width rules:
- In HZD_RUN, redirect_pc=mem_target.
- All outputs are combinational from state and inputs. stall and flush are never both asserted on one register.
- Register compare is exact 3-bit equality. R0 is not special.

Reset:
- While reset_n=0: all flush_* =1, all stall_* =0, pc_load_en=0, pc_redirect=0.
- Reset takes next state HZD_RUN, tgt_q=16'h0000 and counters 0.
- Reset during HZD_FLUSH_PEND discards the buffered target.

## Timing
- Redirect with I-cache ready: 0 extra cycles. PC=target on the next edge.
- Redirect during a fetch: PC loads tgt_q on the edge after icache_resp. It takes N+1 cycles for an N-cycle fetch remainder.
- Load-use: one bubble. The hazard clears the next cycle because the load advances to MEM.
- D-cache wait: full freeze of PC through EX/MEM. WB receives NOPs. The pipeline resumes in the cycle dcache_resp=1.
- dcache_resp and mem_br_taken together: the redirect is honoured that cycle (rule 2).

## Configuration
- PIPE_HZD_PERF_EN defined adds three 16-bit saturating outputs (wrap never, hold at 16'hFFFF), cleared by reset:
  - perf_stall_cycles: cycles with pc_load_en=0 and reset_n=1
  - perf_redirects: accepted mem_br_taken
  - perf_load_use: load_use bubbles
- Undefined: those ports and their logic are absent. Behaviour is otherwise identical.

## Structure
- lc3b_types package gets lc3b_hzd_state (enum HZD_RUN, HZD_FLUSH_PEND). It reuses lc3b_word and lc3b_reg.
- Optional sub-module hzd_perf_counters (three saturating counters), instantiated only under PIPE_HZD_PERF_EN.

## Test plan
- Reset held 2 cycles → flush_* =1, stall_* =0, pc_load_en=0. Release with icache_resp=1 → pc_load_en=1, all flushes 0.
- ex_is_load=1, ex_dest=3, id_sr2_reg=3, id_uses_sr2=1 → one cycle of stall_if_id=1, flush_id_ex=1, pc_load_en=0. Next cycle with ex_is_load=0 → normal.
- mem_br_taken=1, mem_target=16'h3000, icache_resp=1 → pc_redirect=1, redirect_pc=16'h3000, three upstream flushes, state stays HZD_RUN.
- mem_br_taken=1, mem_target=16'h1234, icache_resp=0 for 3 cycles then 1:
  - HZD_FLUSH_PEND for 3 cycles with flush_if_id/id_ex=1 and pc_load_en=0
  - fourth cycle pc_redirect=1, redirect_pc=16'h1234
- dcache_req=1, dcache_resp=0 for 4 cycles with mem_br_taken=1 → freeze outputs, flush_mem_wb=1, no redirect. The redirect is taken in the dcache_resp=1 cycle.
- Reset asserted in HZD_FLUSH_PEND → state HZD_RUN, tgt_q=0. Under PIPE_HZD_PERF_EN, perf counters read 0.
